adder_sub_32bit: RTL and testbench
==================================

// Module: adder_sub_32bit
// PURPOSE
//   Registered 32-bit adder/subtractor with carry/borrow in and out.
//   mode selects A+B+Cin or A-B-Cin; result and carry/borrow are captured on the next clock edge.
//   Sits in datapath ALU slices and accumulator front-ends; purely combinational core plus one output register stage.
// PARAMETERS
//   WIDTH     32   operand/result width in bits (spec and tests written for 32; any WIDTH>=2 must work)
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous, active-high reset
//   a             in   WIDTH  operand A (unsigned)
//   b             in   WIDTH  operand B (unsigned)
//   c_in          in   1      carry-in (add) / borrow-in (sub)
//   mode          in   1      0 = add, 1 = subtract
//   sum_diff      out  WIDTH  registered sum or difference
//   carry_borrow  out  1      registered carry-out (add) / borrow-out (sub)
//   overflow      out  1      registered signed overflow; present only with ADDSUB_OVF_EN
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high: rst=1 immediately forces sum_diff=0, carry_borrow=0 (and overflow=0).
//   - Inputs are sampled every rising clk edge with rst=0; no handshake, no enable; latency exactly 1 cycle, throughput 1/cycle.
//   - mode=0: {carry_borrow,sum_diff} <= a + b + c_in  (WIDTH+1-bit unsigned result).
//   - mode=1: sum_diff <= (a - b - c_in) mod 2^WIDTH; carry_borrow <= 1 iff a < b + c_in (unsigned borrow-out).
//   - Sub implemented as a + ~b + ~c_in through the same adder chain; borrow = NOT(chain carry-out).
//   - Boundaries: add 0xFFFFFFFF+0+1 -> 0, carry 1; sub 0-0-1 -> 0xFFFFFFFF, borrow 1; sub a==b, c_in=0 -> 0, borrow 0.
//   - Inputs changing mid-cycle have no effect until the next edge; X-free outputs after reset.
//   - rst asserted mid-stream discards the pending result; first valid result appears 1 edge after rst deasserts.
// CONFIGURATION
//   ADDSUB_OVF_EN defined: adds port overflow; registered two's-complement overflow of the selected operation
//     (add: a[MSB]==b'[MSB] && res[MSB]!=a[MSB], where b' = b or ~b per mode); reset value 0.
//   ADDSUB_OVF_EN undefined: overflow port and its logic are absent; all other behaviour identical.
// STRUCTURE
//   - Package adder_sub_pkg: WIDTH default constant, MODE_ADD=1'b0, MODE_SUB=1'b1.
//   - Sub-module addsub_fa: 1-bit full adder (a,b,cin -> s,cout); instantiated WIDTH times via generate as ripple chain.
//   - Top: operand-B/c_in inversion by mode, ripple chain, borrow inversion, output register with async reset.
// TESTING
//   - Reset: drive rst=1 with random inputs -> sum_diff=0, carry_borrow=0 asynchronously, held while rst=1.
//   - Add: a=5,b=3,c_in=1,mode=0 -> next edge sum_diff=9, carry_borrow=0.
//   - Add wrap: a=0xFFFFFFFF,b=0x00000001,c_in=0,mode=0 -> sum_diff=0, carry_borrow=1.
//   - Sub: a=10,b=3,c_in=1,mode=1 -> sum_diff=6, carry_borrow=0; a=3,b=10,c_in=0 -> 0xFFFFFFF9, borrow 1.
//   - Random: 50 vectors, a,b in 0..1023, random c_in/mode, 1 vector/cycle -> compare to golden model 1 cycle later.
//   - ADDSUB_OVF_EN: a=0x7FFFFFFF,b=1,mode=0 -> overflow=1; a=0x80000000,b=1,mode=1 -> overflow=1.

Source files
------------

// File: rtl/adder_sub_pkg.sv
// adder_sub_pkg: shared width default and mode encodings for the registered adder/subtractor.
package adder_sub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/addsub_fa.sv
// addsub_fa: 1-bit full adder cell used to build the ripple chain.
module addsub_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_sub_32bit.sv
// adder_sub_32bit: registered ripple add/sub with carry/borrow in and out.
// Define ADDSUB_OVF_EN to add the registered signed overflow output.
module adder_sub_32bit
  import adder_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             mode,
  output logic [WIDTH-1:0] sum_diff,
  output logic             carry_borrow
`ifdef ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   c;
  logic             cb;
  assign sub   = (mode == MODE_SUB);
  // Subtraction reuses the adder: a + ~b + ~c_in, borrow is the inverted carry-out.
  assign b_eff = sub ? ~b : b;
  assign c[0]  = sub ? ~c_in : c_in;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      addsub_fa u_fa (
        .a   (a[i]),
        .b   (b_eff[i]),
        .cin (c[i]),
        .s   (res[i]),
        .cout(c[i+1])
      );
    end
  endgenerate
  assign cb = sub ? ~c[WIDTH] : c[WIDTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_diff     <= '0;
      carry_borrow <= 1'b0;
    end else begin
      sum_diff     <= res;
      carry_borrow <= cb;
    end
`ifdef ADDSUB_OVF_EN
  logic ovf;
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else     overflow <= ovf;
`endif
endmodule

// File: tb/tb_adder_sub_32bit.sv
// tb_adder_sub_32bit: directed and small random checks of the registered add/sub.
module tb_adder_sub_32bit;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         c_in, mode;
  logic [W-1:0] sum_diff;
  logic         carry_borrow;
`ifdef ADDSUB_OVF_EN
  logic         overflow;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_sub_32bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .mode        (mode),
    .sum_diff    (sum_diff),
    .carry_borrow(carry_borrow)
`ifdef ADDSUB_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  // Drive a vector on the falling edge, return 1 ns after the capturing edge.
  task automatic step(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci, input logic m);
    @(negedge clk);
    a = aa; b = bb; c_in = ci; mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    a = $urandom; b = $urandom; c_in = 1'b1; mode = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sum_diff !== '0 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got %h/%b want 0/0", sum_diff, carry_borrow);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; c_in = i[0]; mode = ~i[0];
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum_diff !== '0 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b want 0/0", sum_diff, carry_borrow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    step(32'd5, 32'd3, 1'b1, 1'b0);
    checks++;
    if (sum_diff !== 32'd9 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL add_5_3_1: got %h/%b want 00000009/0", sum_diff, carry_borrow);
    end
    step(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    checks++;
    if (sum_diff !== 32'd0 || carry_borrow !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: got %h/%b want 00000000/1", sum_diff, carry_borrow);
    end
    step(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    checks++;
    if (sum_diff !== 32'd0 || carry_borrow !== 1'b1) begin
      errors++;
      $display("FAIL add_cin_wrap: got %h/%b want 00000000/1", sum_diff, carry_borrow);
    end
    step(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    checks++;
    if (sum_diff !== 32'd1 || carry_borrow !== 1'b1) begin
      errors++;
      $display("FAIL add_msb: got %h/%b want 00000001/1", sum_diff, carry_borrow);
    end
  endtask

  task automatic test_sub;
    step(32'd10, 32'd3, 1'b1, 1'b1);
    checks++;
    if (sum_diff !== 32'd6 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL sub_10_3_1: got %h/%b want 00000006/0", sum_diff, carry_borrow);
    end
    step(32'd3, 32'd10, 1'b0, 1'b1);
    checks++;
    if (sum_diff !== 32'hFFFF_FFF9 || carry_borrow !== 1'b1) begin
      errors++;
      $display("FAIL sub_3_10: got %h/%b want fffffff9/1", sum_diff, carry_borrow);
    end
    step(32'd0, 32'd0, 1'b1, 1'b1);
    checks++;
    if (sum_diff !== 32'hFFFF_FFFF || carry_borrow !== 1'b1) begin
      errors++;
      $display("FAIL sub_0_0_1: got %h/%b want ffffffff/1", sum_diff, carry_borrow);
    end
    step(32'h1234, 32'h1234, 1'b0, 1'b1);
    checks++;
    if (sum_diff !== 32'd0 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL sub_equal: got %h/%b want 00000000/0", sum_diff, carry_borrow);
    end
    step(32'd7, 32'd7, 1'b1, 1'b1);
    checks++;
    if (sum_diff !== 32'hFFFF_FFFF || carry_borrow !== 1'b1) begin
      errors++;
      $display("FAIL sub_equal_bin: got %h/%b want ffffffff/1", sum_diff, carry_borrow);
    end
  endtask

  task automatic test_hold;
    step(32'd40, 32'd2, 1'b0, 1'b0);
    a = 32'd1000; b = 32'd999; c_in = 1'b1; mode = 1'b1;
    #3;
    checks++;
    if (sum_diff !== 32'd42 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL mid_cycle_hold: got %h/%b want 0000002a/0", sum_diff, carry_borrow);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ra, rb, es;
    logic         rc, rm, ec;
    logic [W:0]   wide;
    for (int i = 0; i < 50; i++) begin
      ra = W'($urandom_range(0, 1023));
      rb = W'($urandom_range(0, 1023));
      rc = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      if (rm) begin
        es = ra - rb - W'(rc);
        ec = ({1'b0, ra} < ({1'b0, rb} + (W+1)'(rc)));
      end else begin
        wide = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
        es = wide[W-1:0];
        ec = wide[W];
      end
      step(ra, rb, rc, rm);
      checks++;
      if (sum_diff !== es || carry_borrow !== ec) begin
        errors++;
        $display("FAIL random_%0d: a=%0d b=%0d cin=%b mode=%b got %h/%b want %h/%b",
                 i, ra, rb, rc, rm, sum_diff, carry_borrow, es, ec);
      end
    end
  endtask

  task automatic test_mid_reset;
    step(32'd100, 32'd50, 1'b0, 1'b0);
    checks++;
    if (sum_diff !== 32'd150 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: got %h/%b want 00000096/0", sum_diff, carry_borrow);
    end
    a = 32'd7; b = 32'd9; c_in = 1'b0; mode = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sum_diff !== '0 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %h/%b want 0/0", sum_diff, carry_borrow);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 32'd20; b = 32'd5; c_in = 1'b0; mode = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sum_diff !== 32'd15 || carry_borrow !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got %h/%b want 0000000f/0", sum_diff, carry_borrow);
    end
  endtask

`ifdef ADDSUB_OVF_EN
  task automatic test_overflow;
    step(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_add: got %b want 1", overflow);
    end
    step(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sub: got %b want 1", overflow);
    end
    step(32'd5, 32'd3, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none: got %b want 0", overflow);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_hold;
    test_back_to_back;
    test_mid_reset;
`ifdef ADDSUB_OVF_EN
    test_overflow;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
